// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction-fetch / load-store memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IF_ACC = 2'b01,
        LS_ACC = 2'b10
    } arb_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/wait_timer.sv
// Counts memory wait cycles of the current access; expire_o flags the last allowed wait cycle.
// Purely combinational compare on a registered count; no backpressure of its own.
module wait_timer
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(WAIT_MAX - 1);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This cycle would be wait number WAIT_MAX: abort at the coming edge.
    assign expire_o = inc_i && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one memory port; grant one cycle after request, done one cycle after mem_ready.
// Requesters hold req until done; memory stalls via mem_ready, bounded by WAIT_MAX wait cycles then bus_err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    arb_state_e        state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              last_ls_q, last_ls_d;

    logic req_if, req_ls, grant_ls;
    logic timer_clr, timer_expire;

    wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (timer_clr),
        .inc_i    (mem_en_q & ~mem_ready),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;
        bus_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        last_ls_d   = last_ls_q;
        timer_clr   = 1'b0;
        // A requester still shows req in its own done cycle; mask it so it is not re-granted.
        req_if      = if_req & ~if_done_q;
        req_ls      = ls_req & ~ls_done_q;
        grant_ls    = req_ls & (~req_if | ~last_ls_q);

        case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    state_d     = LS_ACC;
                    mem_en_d    = 1'b1;
                    mem_rw_d    = ls_we;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_we ? ls_wdata : '0;
                    timer_clr   = 1'b1;
                end else if (req_if) begin
                    state_d     = IF_ACC;
                    mem_en_d    = 1'b1;
                    mem_rw_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    timer_clr   = 1'b1;
                end
            end
            IF_ACC, LS_ACC: begin
                if (mem_ready || timer_expire) begin
                    state_d     = IDLE;
                    mem_en_d    = 1'b0;
                    mem_rw_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    bus_err_d   = ~mem_ready;
                    last_ls_d   = (state_q == LS_ACC);
                    if (state_q == IF_ACC) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_ready ? mem_rdata : '0;
                    end else begin
                        ls_done_d = 1'b1;
                        if (!mem_rw_q) begin
                            ls_rdata_d = mem_ready ? mem_rdata : '0;
                        end
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            last_ls_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            bus_err_q   <= bus_err_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            last_ls_q   <= last_ls_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign ls_done   = ls_done_q;
    assign bus_err   = bus_err_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level model of grants, waits, timeouts and read data.
module tb_mem_arbiter;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int WMAX = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, ls_req, ls_we, mem_ready;
    logic [AW-1:0] if_addr, ls_addr, mem_addr;
    logic [DW-1:0] ls_wdata, mem_rdata, if_rdata, ls_rdata, mem_wdata;
    logic          if_done, ls_done, mem_en, mem_rw, bus_err;

    int n_chk  = 0;
    int n_pass = 0;

    // Transaction model state
    bit            in_acc, finishing, timed, e_rw, m_last_ls;
    bit            snap_if, snap_ls, hold_if, hold_ls;
    int            cur, w, lat, n_acc;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, rd_val, m_if_rdata, m_ls_rdata;
    int            lat_q[$];
    logic [DW-1:0] rd_q[$];

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_MAX(WMAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_lat();
        int r;
        if (lat_q.size() > 0) return lat_q.pop_front();
        r = $urandom_range(7);
        if (r <= 5) return $urandom_range(3);
        if (r == 6) return 14 + $urandom_range(1);
        return 15 + $urandom_range(3);
    endfunction

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_mem_en"}, 32'(mem_en), 32'(0));
        check_val({tag, "_mem_rw"}, 32'(mem_rw), 32'(0));
        check_val({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
        check_val({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
        check_val({tag, "_if_done"}, 32'(if_done), 32'(0));
        check_val({tag, "_ls_done"}, 32'(ls_done), 32'(0));
        check_val({tag, "_bus_err"}, 32'(bus_err), 32'(0));
        check_val({tag, "_if_rdata"}, 32'(if_rdata), 32'(0));
        check_val({tag, "_ls_rdata"}, 32'(ls_rdata), 32'(0));
    endtask

    // One cycle of an access in flight: memory port must show the granted request.
    task automatic access_cycle();
        w++;
        check_val("acc_mem_en", 32'(mem_en), 32'(1));
        check_val("acc_mem_addr", 32'(mem_addr), 32'(e_addr));
        check_val("acc_mem_rw", 32'(mem_rw), 32'(e_rw));
        check_val("acc_mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        check_val("acc_dones", 32'({if_done, ls_done, bus_err}), 32'(0));
        mem_ready = (w == lat + 1);
        mem_rdata = mem_ready ? rd_val : DW'($urandom);
        if (w == lat + 1 || w == WMAX) finishing = 1;
    endtask

    task automatic step();
        bit grant_ls;
        @(negedge clk);
        hold_if = 0;
        hold_ls = 0;
        if (finishing) begin
            check_val("done_if", 32'(if_done), 32'(cur == 1));
            check_val("done_ls", 32'(ls_done), 32'(cur == 2));
            check_val("done_bus_err", 32'(bus_err), 32'(timed));
            check_val("done_mem_en", 32'(mem_en), 32'(0));
            if (cur == 1) m_if_rdata = timed ? '0 : rd_val;
            else if (!e_rw) m_ls_rdata = timed ? '0 : rd_val;
            m_last_ls = (cur == 2);
            if (cur == 1) begin if_req = 0; hold_if = 1; end
            else begin ls_req = 0; hold_ls = 1; end
            finishing = 0;
            in_acc = 0;
            mem_ready = 1'($urandom_range(1));
            mem_rdata = DW'($urandom);
        end else if (in_acc) begin
            access_cycle();
        end else if (snap_if || snap_ls) begin
            grant_ls = snap_ls && (!snap_if || !m_last_ls);
            cur      = grant_ls ? 2 : 1;
            e_addr   = grant_ls ? ls_addr : if_addr;
            e_rw     = grant_ls && ls_we;
            e_wdata  = e_rw ? ls_wdata : '0;
            lat      = pick_lat();
            rd_val   = (rd_q.size() > 0) ? rd_q.pop_front() : DW'($urandom);
            timed    = (lat >= WMAX);
            w        = 0;
            in_acc   = 1;
            n_acc++;
            access_cycle();
        end else begin
            check_val("idle_mem_en", 32'(mem_en), 32'(0));
            check_val("idle_dones", 32'({if_done, ls_done, bus_err}), 32'(0));
            mem_ready = 1'($urandom_range(1));
            mem_rdata = DW'($urandom);
        end
        check_val("if_rdata", 32'(if_rdata), 32'(m_if_rdata));
        check_val("ls_rdata", 32'(ls_rdata), 32'(m_ls_rdata));
        if (!if_req && !hold_if && (n_acc < 6 || $urandom_range(2) == 0)) begin
            if_req  = 1;
            if_addr = AW'($urandom);
        end
        if (!ls_req && !hold_ls && (n_acc < 6 || $urandom_range(2) == 0)) begin
            ls_req   = 1;
            ls_we    = 1'($urandom_range(1));
            ls_addr  = AW'($urandom);
            ls_wdata = DW'($urandom);
        end
        snap_if = if_req;
        snap_ls = ls_req;
    endtask

    task automatic model_reset();
        in_acc = 0; finishing = 0; m_last_ls = 0;
        m_if_rdata = '0; m_ls_rdata = '0;
        hold_if = 0; hold_ls = 0;
    endtask

    initial begin
        int k;
        reset     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 16'h0010;
        ls_req    = 1'b1;
        ls_we     = 1'b1;
        ls_addr   = 16'h0001;
        ls_wdata  = 16'hABCD;
        mem_ready = 1'b0;
        mem_rdata = '0;
        n_acc     = 0;
        model_reset();
        lat_q.push_back(0);
        lat_q.push_back(1);
        rd_q.push_back(16'h1111);
        rd_q.push_back(16'h2F03);
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset   = 1'b1;
        snap_if = if_req;
        snap_ls = ls_req;

        repeat (1500) step();

        // Abort an in-flight load/store with reset.
        k = 0;
        while (!(in_acc && cur == 2 && !finishing) && k < 200) begin
            step();
            k++;
        end
        check_val("reach_ls_acc", 32'(in_acc && cur == 2 && !finishing), 32'(1));
        #2 reset = 1'b0;
        #1 check_outputs_zero("mid_rst");
        if_req    = 1'b0;
        ls_req    = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("rst_hold");
        reset   = 1'b1;
        model_reset();
        if_req  = 1'b1;
        if_addr = AW'($urandom);
        snap_if = 1;
        snap_ls = 0;
        n_acc   = 6;
        repeat (400) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, width of memory data word and instruction word.
REQ-002 Parameter ADDR_W, default 16, width of memory address.
REQ-003 Parameter WAIT_MAX, default 15, maximum cycles waiting for mem_ready before timeout.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 if_req  input  1  instruction-fetch request; held high until if_done.
REQ-007 if_addr  input  ADDR_W  fetch address; stable while if_req is high.
REQ-008 if_done  output  1  one-cycle pulse; fetch complete, if_rdata valid.
REQ-009 if_rdata  output  DATA_W  fetched instruction word.
REQ-010 ls_req  input  1  load/store request; held high until ls_done.
REQ-011 ls_we  input  1  1 = store, 0 = load; stable while ls_req is high.
REQ-012 ls_addr  input  ADDR_W  data address.
REQ-013 ls_wdata  input  DATA_W  store data.
REQ-014 ls_done  output  1  one-cycle pulse; load/store complete, ls_rdata valid for loads.
REQ-015 ls_rdata  output  DATA_W  load data.
REQ-016 mem_en  output  1  memory access active.
REQ-017 mem_rw  output  1  1 = write, 0 = read (same polarity as rw_mem).
REQ-018 mem_addr  output  ADDR_W  memory address.
REQ-019 mem_wdata  output  DATA_W  memory write data.
REQ-020 mem_ready  input  1  memory completes the current access this cycle.
REQ-021 mem_rdata  input  DATA_W  read data, valid when mem_ready is high.
REQ-022 bus_err  output  1  one-cycle pulse on access timeout.

Function
REQ-023 States: IDLE, IF_ACC, LS_ACC; the FSM is registered and the outputs are registered.
REQ-024 IDLE: if only ls_req is high, go to LS_ACC; if only if_req is high, go to IF_ACC; if both are high, grant the requester that was not served last (last_ls flag, reset value 0, so LS wins the first tie).
REQ-025 Grant latency: mem_en rises on the cycle after the request is sampled in IDLE; mem_addr, mem_rw and mem_wdata are latched from the granted requester at that edge.
REQ-026 In IF_ACC, mem_rw is 0; in LS_ACC, mem_rw is ls_we; mem_wdata is ls_wdata for a store and 0 otherwise.
REQ-027 Access completes on the first cycle with mem_ready=1 while mem_en=1: the next edge returns to IDLE, drops mem_en, pulses the matching done signal, and captures mem_rdata into if_rdata, or into ls_rdata for a load.
REQ-028 Stores leave ls_rdata unchanged.
REQ-029 Wait counter is ADDR-independent, 4 bits sized for WAIT_MAX, cleared on grant, and increments each cycle mem_en=1 and mem_ready=0.
REQ-030 When the counter reaches WAIT_MAX without mem_ready, the access aborts: done pulse, rdata=0 for a read, bus_err pulse in the same cycle, return to IDLE.
REQ-031 No back-to-back grant without passing through IDLE; minimum access cost is 3 cycles (grant, ready, done).
REQ-032 A request that drops before done is ignored once in flight; the access completes normally.
REQ-033 mem_ready while mem_en=0 has no effect.
REQ-034 last_ls is updated at every completion, including a timeout.

Reset
REQ-035 reset=0 asynchronously forces IDLE, mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0, if_done=0, ls_done=0, bus_err=0, if_rdata=0, ls_rdata=0, counter=0, last_ls=0.
REQ-036 Reset mid-access abandons the access with no done pulse; operation resumes from IDLE on the first edge after release.

Structure
REQ-037 The shared package holds the state encoding (IDLE=2'b00, IF_ACC=2'b01, LS_ACC=2'b10) and the default DATA_W/ADDR_W constants.
REQ-038 One sub-module, wait_timer (counter plus timeout compare), is instantiated inside mem_arbiter.

Verification
REQ-039 if_req=1, if_addr=16'h0010, mem_ready one cycle after mem_en, mem_rdata=16'h2F03 -> if_done pulse, if_rdata=16'h2F03, mem_rw=0 throughout.
REQ-040 ls_req=1, ls_we=1, ls_addr=16'h0001, ls_wdata=16'hABCD -> mem_rw=1, mem_wdata=16'hABCD, ls_done pulse, ls_rdata unchanged.
REQ-041 if_req and ls_req both high from reset release -> LS served first, then IF, then LS on repeat, alternating.
REQ-042 ls_req load with mem_ready held 0 -> after WAIT_MAX=15 wait cycles, ls_done and bus_err pulse together, ls_rdata=0.
REQ-043 Drive reset=0 during LS_ACC -> all outputs are 0 immediately, with no ls_done; after release, a fresh if_req is granted normally.
